accumulator_drain_unit: RTL
===========================

// Module: accumulator_drain_unit
// PURPOSE
//  Downstream of the accumulator control unit: once a tile pass completes, reads every accumulator row,
//  applies optional ReLU plus rounding right-shift requantisation, saturates each lane to int8 and
//  writes rows to the unified buffer over a valid/ready handshake. Sustains 1 row/clk without
//  backpressure and loses no row under backpressure.
// PARAMETERS
//  MUL_SIZE  32  lanes per row (systolic array width)
//  ACC_W     32  accumulator lane width, signed
//  OUT_W     8   output lane width, signed
//  ADDR_W    10  accumulator and unified-buffer row address width
// PORTS
//  clk_i          in   1                 clock, rising edge
//  rst_i          in   1                 reset, synchronous, active-low
//  start_i        in   1                 1-clk pulse; drain begins (driven by accumulator done)
//  V_dim_i        in   7                 V dimension; sampled on accepted start
//  U_dim_i        in   7                 U dimension; sampled on accepted start
//  shift_i        in   5                 requant right-shift; sampled on accepted start
//  relu_en_i      in   1                 1 = clamp negatives to 0; sampled on accepted start
//  acc_rd_en_o    out  1                 accumulator read strobe
//  acc_rd_addr_o  out  ADDR_W            accumulator read row
//  acc_rd_data_i  in   MUL_SIZE*ACC_W    row data, valid 1 clk after acc_rd_en_o; lane 0 = LSBs
//  ub_wr_valid_o  out  1                 output row valid
//  ub_wr_ready_i  in   1                 unified buffer accepts row when valid&&ready
//  ub_wr_addr_o   out  ADDR_W            unified-buffer row (= source accumulator row)
//  ub_wr_data_o   out  MUL_SIZE*OUT_W    requantised row; lane 0 = LSBs
//  busy_o         out  1                 high from accepted start through done
//  done_o         out  1                 1-clk pulse after last row handshake
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; counters and FIFO cleared. Reset mid-drain aborts immediately;
//   no write after reset deasserts until a new start.
//  rows = ((V_dim_i>>5)*(U_dim_i>>5))<<5, 10-bit, computed at start.
//  FSM: IDLE -start_i-> (rows==0 ? DONE : DRAIN); DRAIN issues reads at rows 0..rows-1 ascending,
//   -> FLUSH after last read issued; FLUSH -> DONE when FIFO empty and no read in flight;
//   DONE asserts done_o for 1 clk -> IDLE. start_i outside IDLE is ignored.
//  Read issue: acc_rd_en_o=1 in a cycle only if in DRAIN and (FIFO occupancy + reads in flight) < 2.
//  Pipeline: cycle N read; N+1 data captured and requantised into FIFO; FIFO head drives ub_wr_*.
//   First ub_wr_valid_o 2 clk after first acc_rd_en_o. Stable ready=1: 1 row/clk,
//   done_o exactly 2 clk after last handshake.
//  Handshake: ub_wr_valid_o, ub_wr_addr_o and ub_wr_data_o held stable until accepted;
//   valid never drops without handshake.
//  Lane math: x signed ACC_W; if relu && x<0 -> x=0. If shift>0: y=(x + (1<<(shift-1)))>>>shift
//   in ACC_W+1 bits (no overflow at max); else y=x. Saturate y to [-128,127].
//  FIFO simultaneous push+pop when full: legal only because occupancy cap counts in-flight reads;
//   FIFO overflow is an assertion failure.
// STRUCTURE
//  tpu_package: ACC_W, OUT_W, ADDR_W constants; drain_state_t enum {IDLE,DRAIN,FLUSH,DONE};
//   function requant_lane(acc, shift, relu) returning OUT_W signed.
//  Sub-module drain_skid_fifo: 2-entry FIFO of {addr,data}, push/pop/full/empty, synchronous clear.
// TESTING
//  V=64,U=64,shift=0,relu=0,ready=1, row r lanes = r -> 128 writes addr 0..127, data lane=sat(r), done 2 clk after last.
//  Lane values {-200,-1,127,300}, shift=0, relu=1 -> {0,0,127,127}; relu=0 -> {-128,-1,127,127}.
//  shift=4, lane values {24,23,-24,-25} -> {2,1,-1,-2} (round half up toward +inf).
//  V=32,U=32, ready toggles 1,0,0,1 repeating -> 32 rows in order, no drop/duplicate, data stable while stalled.
//  V=16 (rows=0), start -> no acc_rd_en_o, no write, done_o 2 clk after start; start during busy ignored.
//  rst_i low mid-drain at row 10 -> all outputs 0 next clk; new start re-drains from row 0.

Source files
------------

// File: rtl/tpu_package.sv
// Shared widths, drain FSM states and the per-lane requantisation used by the
// accumulator drain path.
package tpu_package;

  localparam int ACC_W  = 32;
  localparam int OUT_W  = 8;
  localparam int ADDR_W = 10;

  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} drain_state_t;

  // One extra bit of headroom keeps the rounding add from wrapping at the positive limit.
  function automatic logic signed [OUT_W-1:0] requant_lane(
    input logic signed [ACC_W-1:0] acc,
    input logic        [4:0]       shift,
    input logic                    relu
  );
    logic signed [ACC_W:0] x;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] y;
    x   = (relu && acc[ACC_W-1]) ? '0 : {acc[ACC_W-1], acc};
    rnd = (ACC_W+1)'(1) << (shift - 5'd1);
    if (shift == '0) y = x;
    else             y = (x + rnd) >>> shift;
    if (y > SAT_HI)      return OUT_W'(SAT_HI);
    else if (y < SAT_LO) return OUT_W'(SAT_LO);
    else                 return y[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/drain_skid_fifo.sv
// Two-entry FIFO holding {row address, requantised row} between the accumulator
// read pipeline and the unified-buffer handshake.
module drain_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  // Push while full is only safe alongside a pop: the write lands in the slot being vacated.
  always_ff @(posedge clk_i) begin
    if (!rst_i || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);

  overflow_chk:  assert property (@(posedge clk_i) disable iff (!rst_i) !(push && full && !pop));
  underflow_chk: assert property (@(posedge clk_i) disable iff (!rst_i) !(pop && empty));

endmodule

// File: rtl/accumulator_drain_unit.sv
// Drains accumulator rows after a tile pass: read, requantise to int8, and hand
// each row to the unified buffer over valid/ready without losing rows on stalls.
module accumulator_drain_unit
  import tpu_package::*;
#(
  parameter int MUL_SIZE = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [6:0]                V_dim_i,
  input  logic [6:0]                U_dim_i,
  input  logic [4:0]                shift_i,
  input  logic                      relu_en_i,
  output logic                      acc_rd_en_o,
  output logic [ADDR_W-1:0]         acc_rd_addr_o,
  input  logic [MUL_SIZE*ACC_W-1:0] acc_rd_data_i,
  output logic                      ub_wr_valid_o,
  input  logic                      ub_wr_ready_i,
  output logic [ADDR_W-1:0]         ub_wr_addr_o,
  output logic [MUL_SIZE*OUT_W-1:0] ub_wr_data_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int ROW_W   = MUL_SIZE * OUT_W;
  localparam int ENTRY_W = ADDR_W + ROW_W;

  drain_state_t        state;
  logic [ADDR_W-1:0]   rows_q;
  logic [4:0]          shift_q;
  logic                relu_q;
  logic [ADDR_W-1:0]   rd_ptr;
  logic                rd_pending;
  logic [ADDR_W-1:0]   pend_addr;
  logic [6:0]          v_tiles;
  logic [6:0]          u_tiles;
  logic [ADDR_W-1:0]   rows_calc;
  logic [ROW_W-1:0]    row_q8;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic                start_ok;

  assign start_ok  = (state == IDLE) && start_i;
  assign v_tiles   = V_dim_i >> 5;
  assign u_tiles   = U_dim_i >> 5;
  assign rows_calc = ADDR_W'(v_tiles * u_tiles) << 5;

  assign ub_wr_valid_o = !fifo_empty;
  assign pop           = ub_wr_valid_o && ub_wr_ready_i;

  // FIFO slots plus the read in flight are the credits; a pop this cycle returns one,
  // which is what lets the pipe run at a row per clock.
  assign acc_rd_en_o   = (state == DRAIN) &&
                         (fifo_empty || (!fifo_full && !rd_pending) || pop);
  assign acc_rd_addr_o = rd_ptr;

  assign ub_wr_addr_o  = fifo_empty ? '0 : fifo_head[ENTRY_W-1 -: ADDR_W];
  assign ub_wr_data_o  = fifo_empty ? '0 : fifo_head[ROW_W-1:0];

  always_comb begin
    row_q8 = '0;
    for (int i = 0; i < MUL_SIZE; i++)
      row_q8[i*OUT_W +: OUT_W] = requant_lane(acc_rd_data_i[i*ACC_W +: ACC_W], shift_q, relu_q);
  end

  drain_skid_fifo #(
    .W (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (start_ok),
    .push    (rd_pending),
    .pop     (pop),
    .wr_data ({pend_addr, row_q8}),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      rows_q     <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      rd_ptr     <= '0;
      rd_pending <= 1'b0;
      pend_addr  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      rd_pending <= acc_rd_en_o;
      pend_addr  <= rd_ptr;
      done_o     <= 1'b0;
      case (state)
        IDLE: begin
          busy_o <= start_i;
          if (start_i) begin
            rows_q  <= rows_calc;
            shift_q <= shift_i;
            relu_q  <= relu_en_i;
            rd_ptr  <= '0;
            state   <= (rows_calc == '0) ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          if (acc_rd_en_o) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            if (rd_ptr == rows_q - ADDR_W'(1)) state <= FLUSH;
          end
        end
        // Leave as soon as the last row is being accepted so done lands two clocks after it.
        FLUSH: begin
          if (!rd_pending && (fifo_empty || (!fifo_full && pop))) state <= DONE;
        end
        DONE: begin
          done_o <= 1'b1;
          rd_ptr <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
